// File: rtl/aq_ejpeg_rgb2ycbcr_if.sv
// rtl/aq_ejpeg_rgb2ycbcr_if.sv - pixel input and component-sample output bundle for the RGB-to-YCbCr front end
interface aq_ejpeg_rgb2ycbcr_if;
  logic       ProcessInit;
  logic [2:0] JpegComp;
  logic       InValid;
  logic       InReady;
  logic [7:0] InR;
  logic [7:0] InG;
  logic [7:0] InB;
  logic       OutValid;
  logic       OutReady;
  logic [1:0] OutComp;
  logic [5:0] OutIndex;
  logic [8:0] OutData;
  logic       OutBlockEnd;
  logic       Idle;

  modport master (
    output ProcessInit, JpegComp, InValid, InR, InG, InB, OutReady,
    input  InReady, OutValid, OutComp, OutIndex, OutData, OutBlockEnd, Idle
  );

  modport slave (
    input  ProcessInit, JpegComp, InValid, InR, InG, InB, OutReady,
    output InReady, OutValid, OutComp, OutIndex, OutData, OutBlockEnd, Idle
  );
endinterface

// File: rtl/aq_ejpeg_rgb2ycbcr.sv
// rtl/aq_ejpeg_rgb2ycbcr.sv - RGB to YCbCr converter with double-buffered 8x8 block store feeding the forward DCT
module aq_ejpeg_rgb2ycbcr #(
  parameter bit LEVEL_SHIFT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  aq_ejpeg_rgb2ycbcr_if.slave   bus
);

  typedef enum logic {ST_IDLE, ST_READ} rd_state_e;

  typedef struct packed {
    logic       vld;
    logic       bank;
    logic [5:0] idx;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } s0_t;

  typedef struct packed {
    logic        vld;
    logic        bank;
    logic [5:0]  idx;
    logic [16:0] y;
    logic [16:0] cb;
    logic [16:0] cr;
  } s1_t;

  typedef struct packed {
    logic       vld;
    logic       bank;
    logic [5:0] idx;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } s2_t;

  logic              clr;
  logic              init_done_q, init_done_d;
  logic              gray_q, gray_d;
  logic              in_bank_q, in_bank_d;
  logic [5:0]        in_idx_q, in_idx_d;
  s0_t               s0_q, s0_d;
  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  logic [1:0]        full_q, full_d;
  rd_state_e         st_q, st_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        rd_comp_q, rd_comp_d;
  logic [5:0]        rd_idx_q, rd_idx_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [7:0]        mem_y  [128];
  logic [7:0]        mem_cb [128];
  logic [7:0]        mem_cr [128];

  logic              fire, last, wr_ok, pipe_adv, s2_wr, in_fire;
  logic [1:0]        last_comp;
  logic [6:0]        rd_addr;
  logic signed [16:0] pr, pg, pb, t_y, t_cb, t_cr;
  logic [8:0]        out_sample;

  function automatic logic [7:0] clamp8(input logic signed [16:0] v);
    if (v < 17'sd0)        return 8'd0;
    else if (v > 17'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

  assign clr = rst | bus.ProcessInit;

  // A pixel waiting to be written may land in the bank being released on this very edge.
  always_comb begin
    last_comp = gray_q ? 2'd0 : 2'd2;
    fire      = (st_q == ST_READ) && bus.OutReady;
    last      = fire && (rd_idx_q == 6'd63) && (rd_comp_q == last_comp);
    wr_ok     = !full_q[s2_q.bank] || (last && (rd_bank_q == s2_q.bank));
    pipe_adv  = !s2_q.vld || wr_ok;
    s2_wr     = s2_q.vld && wr_ok;
    in_fire   = bus.InValid && bus.InReady;
  end

  always_comb begin
    init_done_d = 1'b1;
    gray_d      = gray_q;
    if (bus.ProcessInit) gray_d = (bus.JpegComp == 3'd1);
    in_idx_d  = in_idx_q;
    in_bank_d = in_bank_q;
    if (in_fire) begin
      in_idx_d = in_idx_q + 6'd1;
      if (in_idx_q == 6'd63) in_bank_d = ~in_bank_q;
    end
    full_d = full_q;
    if (last) full_d[rd_bank_q] = 1'b0;
    if (s2_wr && (s2_q.idx == 6'd63)) full_d[s2_q.bank] = 1'b1;
  end

  always_comb begin
    pr   = $signed({9'd0, s0_q.r});
    pg   = $signed({9'd0, s0_q.g});
    pb   = $signed({9'd0, s0_q.b});
    t_y  = $signed(s1_q.y) >>> 8;
    t_cb = ($signed(s1_q.cb) >>> 8) + 17'sd128;
    t_cr = ($signed(s1_q.cr) >>> 8) + 17'sd128;
    s0_d = s0_q;
    s1_d = s1_q;
    s2_d = s2_q;
    if (pipe_adv) begin
      s0_d.vld  = in_fire;
      s0_d.bank = in_bank_q;
      s0_d.idx  = in_idx_q;
      s0_d.r    = bus.InR;
      s0_d.g    = bus.InG;
      s0_d.b    = bus.InB;
      s1_d.vld  = s0_q.vld;
      s1_d.bank = s0_q.bank;
      s1_d.idx  = s0_q.idx;
      s1_d.y    = 17'sd77 * pr + 17'sd150 * pg + 17'sd29 * pb + 17'sd128;
      s1_d.cb   = 17'sd128 * pb - 17'sd43 * pr - 17'sd85 * pg + 17'sd128;
      s1_d.cr   = 17'sd128 * pr - 17'sd107 * pg - 17'sd21 * pb + 17'sd128;
      s2_d.vld  = s1_q.vld;
      s2_d.bank = s1_q.bank;
      s2_d.idx  = s1_q.idx;
      s2_d.y    = clamp8(t_y);
      s2_d.cb   = clamp8(t_cb);
      s2_d.cr   = clamp8(t_cr);
    end
  end

  // Read address follows the next-state pointer so the registered read always matches the presented sample.
  always_comb begin
    st_d      = st_q;
    rd_bank_d = rd_bank_q;
    rd_comp_d = rd_comp_q;
    rd_idx_d  = rd_idx_q;
    case (st_q)
      ST_IDLE: if (full_q[rd_bank_q]) st_d = ST_READ;
      ST_READ: begin
        if (last) begin
          rd_bank_d = ~rd_bank_q;
          rd_comp_d = 2'd0;
          rd_idx_d  = 6'd0;
          st_d      = full_q[~rd_bank_q] ? ST_READ : ST_IDLE;
        end else if (fire) begin
          rd_idx_d = rd_idx_q + 6'd1;
          if (rd_idx_q == 6'd63) rd_comp_d = rd_comp_q + 2'd1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    rd_addr = {rd_bank_d, rd_idx_d};
    case (rd_comp_d)
      2'd0:    rdata_d = mem_y[rd_addr];
      2'd1:    rdata_d = mem_cb[rd_addr];
      default: rdata_d = mem_cr[rd_addr];
    endcase
  end

  always_ff @(posedge clk) begin
    if (s2_wr) begin
      mem_y[{s2_q.bank, s2_q.idx}]  <= s2_q.y;
      mem_cb[{s2_q.bank, s2_q.idx}] <= s2_q.cb;
      mem_cr[{s2_q.bank, s2_q.idx}] <= s2_q.cr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) gray_q <= 1'b0;
    else     gray_q <= gray_d;
    if (clr) begin
      init_done_q <= 1'b0;
      in_bank_q   <= 1'b0;
      in_idx_q    <= 6'd0;
      s0_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      full_q      <= 2'b00;
      st_q        <= ST_IDLE;
      rd_bank_q   <= 1'b0;
      rd_comp_q   <= 2'd0;
      rd_idx_q    <= 6'd0;
      rdata_q     <= 8'd0;
    end else begin
      init_done_q <= init_done_d;
      in_bank_q   <= in_bank_d;
      in_idx_q    <= in_idx_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      full_q      <= full_d;
      st_q        <= st_d;
      rd_bank_q   <= rd_bank_d;
      rd_comp_q   <= rd_comp_d;
      rd_idx_q    <= rd_idx_d;
      rdata_q     <= rdata_d;
    end
  end

  assign out_sample      = LEVEL_SHIFT ? ({1'b0, rdata_q} - 9'd128) : {1'b0, rdata_q};
  assign bus.InReady     = init_done_q && pipe_adv;
  assign bus.OutValid    = (st_q == ST_READ);
  assign bus.OutComp     = rd_comp_q;
  assign bus.OutIndex    = rd_idx_q;
  assign bus.OutData     = bus.OutValid ? out_sample : 9'd0;
  assign bus.OutBlockEnd = bus.OutValid && (rd_idx_q == 6'd63) && (rd_comp_q == last_comp);
  assign bus.Idle        = (st_q == ST_IDLE) && (full_q == 2'b00) && !s0_q.vld && !s1_q.vld
                           && !s2_q.vld && (in_idx_q == 6'd0);

endmodule

// File: doc/aq_ejpeg_rgb2ycbcr.md
Name: aq_ejpeg_rgb2ycbcr

Overview:
- Front end of the JPEG encoder: the mirror of the decoder's YCbCr-to-RGB output stage.
- Accepts RGB pixels in 8x8-block order and converts them to YCbCr in fixed point.
- Stores each block in a double-buffered block memory, then emits one 64-sample component block per component (Y, Cb, Cr; Y only for grayscale) to the forward DCT, level-shifted to signed 9 bits.
- Only 4:4:4 and 4:0:0 are supported; chroma subsampling is out of scope for this block.

Parameters:
LEVEL_SHIFT, 1, when 1 subtract 128 from every output sample; when 0 output 0..255 zero-extended

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ProcessInit  in  1  one-cycle pulse; flushes both banks and pipeline, latches JpegComp
JpegComp  in  3  component count; 1 = grayscale, any other value = 3 components
InValid  in  1  input pixel valid
InReady  out  1  block accepts pixel this cycle
InR  in  8  red
InG  in  8  green
InB  in  8  blue
OutValid  out  1  output sample valid
OutReady  in  1  downstream (DCT) accepts sample
OutComp  out  2  0=Y, 1=Cb, 2=Cr
OutIndex  out  6  sample index in block, row-major 0..63
OutData  out  9  sample, two's complement
OutBlockEnd  out  1  high with the sample at OutIndex 63 of the last component of a block
Idle  out  1  both banks empty, pipeline empty, no output pending

Behaviour:
- Reset, synchronous on rst=1 at clk edge:
  - InReady=0, OutValid=0, OutComp=0, OutIndex=0, OutData=0, OutBlockEnd=0, Idle=1.
  - Latched component mode = 3.
  - InReady rises the cycle after rst deasserts.
- ProcessInit has the same effect as rst, except that it latches JpegComp. A block in progress is discarded and no partial block is ever output.
- A pixel is accepted on an edge with InValid & InReady. Pixels are counted 0..63 into the current write bank.
- Conversion: 2-stage pipeline, products 17 bits signed, arithmetic right shift, then clamp 0..255.
  - Y = (77R+150G+29B+128)>>8
  - Cb = ((-43R-85G+128B+128)>>8)+128
  - Cr = ((128R-107G-21B+128)>>8)+128
  - With LEVEL_SHIFT=1, OutData = value-128, range -128..127.
- Banks: two banks, each holding 3x64 entries.
  - The write bank is committed full when pixel 63 reaches memory.
  - InReady=0 while both banks are full, or while the write bank is full and its last pipeline write is pending. Pixels in flight are never dropped.
  - Bank handoff ping-pongs: write bank 0, then 1, then 0, and so on. The read side always drains the oldest full bank first.
- Read FSM states:
  - IDLE: a full bank exists -> READ.
  - READ: presents OutComp/OutIndex/OutData; advances on OutValid & OutReady.
    - Order is index 0..63 for comp 0, then comp 1, then comp 2.
    - In grayscale mode, comp 0 only.
  - After the final sample: the bank is released on the same edge; go to READ if the other bank is full, else IDLE.
- Memory read latency is 1 cycle, absorbed internally.
- OutValid/OutComp/OutIndex/OutData/OutBlockEnd hold stable while OutValid & !OutReady.
- With OutReady held high, the output is one sample per cycle with no bubbles within a block or between back-to-back full banks.
- Latency: pixel 63 accepted at edge N gives OutValid=1 from cycle N+4 when the read side is idle.
- Simultaneous release of the read bank and commit of the write bank on one edge: both take effect. InReady returns high the next cycle.
- Throughput: grayscale sustains one pixel/cycle. 3-component mode is output-bound at one block per 192 cycles, and the input stalls accordingly.
- JpegComp changes without ProcessInit are ignored.

Test Plan:
- rst high 2 cycles, then low -> all outputs at reset values, Idle=1; InReady=1 on the cycle after deassert.
- JpegComp=3, 64 pixels R=G=B=255, OutReady=1 -> 192 samples: Y all 127, Cb all 0, Cr all 0; OutValid at N+4; OutBlockEnd only on (comp 2, index 63).
- JpegComp=3, pure red (255,0,0) -> Y=-51, Cb=-43, Cr=127 (clamped). Black (0,0,0) -> Y=-128, Cb=0, Cr=0.
- JpegComp=1, 3 blocks back-to-back, InValid and OutReady always high -> exactly 192 samples, all OutComp=0, InReady never low, no output bubbles.
- JpegComp=3, OutReady=0 while feeding 3 blocks -> InReady drops after 128 pixels plus those in flight. Outputs hold stable while stalled. On release, data order and values are intact and no pixel is lost.
- ProcessInit pulsed after 30 pixels of a block, then one full block fed -> only the new block is output, index starting at 0; Idle=1 after it drains.
